thread_regfile: RTL and testbench
=================================

THREAD_REGFILE -- requirements
Module: thread_regfile

Interface
REQ-001 SHALL have parameter THREADS_PER_BLOCK, default 4, value returned by read-only register R14 (%blockDim).
REQ-002 SHALL have parameter THREAD_ID, default 0, value returned by read-only register R15 (%threadIdx).
REQ-003 SHALL have parameter DATA_BITS, default 8, width of every data register and data port.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low; asserted (0) clears state immediately.
REQ-006 SHALL have port enable  in  1  thread active in current block; 0 freezes all state.
REQ-007 SHALL have port block_id  in  8  current block index, mirrored into R13 (%blockIdx).
REQ-008 SHALL have port core_state  in  3  core FSM state: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
REQ-009 SHALL have ports decoded_rd_address, decoded_rs_address, decoded_rt_address  in  4 each  register indices.
REQ-010 SHALL have port decoded_reg_write_enable  in  1  instruction writes rd.
REQ-011 SHALL have port decoded_reg_input_mux  in  2  writeback source: 00 alu_out, 01 lsu_out, 10 decoded_immediate, 11 reserved.
REQ-012 SHALL have ports decoded_immediate, alu_out, lsu_out  in  DATA_BITS each  writeback candidates.
REQ-013 SHALL have port decoded_nzp_write_enable  in  1  capture compare flags (CMP instruction).
REQ-014 SHALL have ports rs, rt  out  DATA_BITS each  registered operand values to ALU/LSU.
REQ-015 SHALL have port nzp  out  3  registered flags {positive, zero, negative}.

Function
REQ-016 SHALL hold 16 registers: R0-R12 general purpose, R13-R15 read-only special.
REQ-017 SHALL, when enable=1, load R13 from block_id on every clock edge.
REQ-018 SHALL, when enable=1 and core_state=REQUEST, register rs<=R[decoded_rs_address] and rt<=R[decoded_rt_address]; values valid the cycle after the REQUEST edge and held until the next REQUEST.
REQ-019 SHALL, when enable=1, core_state=UPDATE, decoded_reg_write_enable=1 and decoded_rd_address<=12, write the source selected by decoded_reg_input_mux into R[rd].
REQ-020 SHALL ignore writes with rd in 13..15 and writes with mux=11; no register changes.
REQ-021 SHALL, when enable=1, core_state=UPDATE and decoded_nzp_write_enable=1, load nzp<=alu_out[2:0].
REQ-022 SHALL perform no read, write or nzp update in any other core_state or when enable=0; R13 also frozen when enable=0.
REQ-023 SHALL allow rs/rt address equal to rd; no conflict exists since reads and writes occur in different states.
REQ-024 SHALL store values verbatim; no width extension, saturation or wrap-around logic.

Reset
REQ-025 SHALL on reset=0 asynchronously set R0-R13=0, R14=THREADS_PER_BLOCK, R15=THREAD_ID, rs=0, rt=0, nzp=000.
REQ-026 SHALL, if reset asserts mid-instruction, discard any pending read/write; first update after release follows normal rules.

Configuration
REQ-027 SHALL honour macro THREAD_REGFILE_NZP_EN: defined -> nzp register and REQ-021 implemented; undefined -> nzp tied to 000, decoded_nzp_write_enable ignored, no nzp flops.

Structure
REQ-028 SHALL take core-state encoding, writeback-mux encoding and special register indices (13,14,15) from shared package gpu_pkg.
REQ-029 SHALL be a single flat module; no sub-module.

Verification
REQ-030 SHALL cover reset: reset=0 with THREAD_ID=2, THREADS_PER_BLOCK=4 -> read R13/R14/R15 yields 0/4/2, nzp=000.
REQ-031 SHALL cover writeback: UPDATE, rd=3, mux=00, alu_out=0x2A, then REQUEST rs=3 -> rs=0x2A next cycle; repeat mux=01 lsu_out=0x11, mux=10 imm=0x7F.
REQ-032 SHALL cover protection: UPDATE rd=14, wren=1, alu_out=0xFF -> R14 still 4; mux=11 rd=5 -> R5 unchanged.
REQ-033 SHALL cover state gating: wren=1 rd=1 in EXECUTE or with enable=0 -> R1 unchanged; block_id=7 with enable=0 -> R13 unchanged, enable=1 -> R13=7.
REQ-034 SHALL cover nzp: UPDATE, nzp_we=1, alu_out=0x02 -> nzp=010; with macro undefined -> nzp=000.
REQ-035 SHALL cover async reset mid-UPDATE: reset=0 between edges -> all state at reset values before next edge.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: core FSM state encoding, writeback source select
// and the indices of the read-only special registers.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LSU  = 2'b01,
        WB_IMM  = 2'b10,
        WB_RSVD = 2'b11
    } wb_mux_e;

    localparam logic [3:0] LAST_GP_REG    = 4'd12;
    localparam logic [3:0] REG_BLOCK_IDX  = 4'd13;
    localparam logic [3:0] REG_BLOCK_DIM  = 4'd14;
    localparam logic [3:0] REG_THREAD_IDX = 4'd15;

endpackage

// File: rtl/thread_regfile.sv
// Per-thread register file: R0-R12 general purpose, R13 %blockIdx, R14 %blockDim, R15 %threadIdx.
// Define THREAD_REGFILE_NZP_EN to implement the compare-flag (nzp) register.
module thread_regfile
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic                 decoded_nzp_write_enable,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt,
    output logic [2:0]           nzp
);

    localparam logic [DATA_BITS-1:0] BLOCK_DIM_VAL  = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] THREAD_IDX_VAL = DATA_BITS'(THREAD_ID);

    // R14/R15 never change, so only R0-R13 are stored.
    logic [13:0][DATA_BITS-1:0] regs_q, regs_d;
    logic [15:0][DATA_BITS-1:0] reg_view;
    logic [DATA_BITS-1:0]       rs_q, rs_d;
    logic [DATA_BITS-1:0]       rt_q, rt_d;
    logic [DATA_BITS-1:0]       wb_data;
    logic                       wb_valid;
    logic                       is_request;
    logic                       is_update;

    assign is_request = enable && (core_state == CORE_REQUEST);
    assign is_update  = enable && (core_state == CORE_UPDATE);

    always_comb begin
        reg_view = {THREAD_IDX_VAL, BLOCK_DIM_VAL, regs_q};
    end

    always_comb begin
        wb_data  = '0;
        wb_valid = 1'b1;
        case (wb_mux_e'(decoded_reg_input_mux))
            WB_ALU:  wb_data = alu_out;
            WB_LSU:  wb_data = lsu_out;
            WB_IMM:  wb_data = decoded_immediate;
            default: wb_valid = 1'b0;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        rs_d   = rs_q;
        rt_d   = rt_q;
        if (enable) begin
            regs_d[REG_BLOCK_IDX] = DATA_BITS'(block_id);
        end
        if (is_request) begin
            rs_d = reg_view[decoded_rs_address];
            rt_d = reg_view[decoded_rt_address];
        end
        // Special registers are excluded by the rd bound, so R13 never sees two writers.
        if (is_update && decoded_reg_write_enable && wb_valid &&
            (decoded_rd_address <= LAST_GP_REG)) begin
            regs_d[decoded_rd_address] = wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
        end else begin
            regs_q <= regs_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
        end
    end

    assign rs = rs_q;
    assign rt = rt_q;

`ifdef THREAD_REGFILE_NZP_EN
    logic [2:0] nzp_q, nzp_d;

    always_comb begin
        nzp_d = nzp_q;
        if (is_update && decoded_nzp_write_enable) begin
            nzp_d = alu_out[2:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nzp_q <= '0;
        end else begin
            nzp_q <= nzp_d;
        end
    end

    assign nzp = nzp_q;
`else
    logic unused_nzp_we;
    assign unused_nzp_we = decoded_nzp_write_enable;
    assign nzp           = '0;
`endif

endmodule

// File: tb/tb_thread_regfile.sv
// Directed bench for thread_regfile (THREAD_ID=2, THREADS_PER_BLOCK=4, DATA_BITS=8).
module tb_thread_regfile;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [3:0] rd_addr, rs_addr, rt_addr;
    logic       reg_we;
    logic [1:0] wb_mux;
    logic [7:0] imm, alu_out, lsu_out;
    logic       nzp_we;
    logic [7:0] rs, rt;
    logic [2:0] nzp;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_EXECUTE = 3'b101;
    localparam logic [2:0] ST_UPDATE  = 3'b110;

`ifdef THREAD_REGFILE_NZP_EN
    localparam logic [2:0] NZP_EXP = 3'b010;
`else
    localparam logic [2:0] NZP_EXP = 3'b000;
`endif

    thread_regfile #(
        .THREADS_PER_BLOCK (4),
        .THREAD_ID         (2),
        .DATA_BITS         (8)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .block_id                 (block_id),
        .core_state               (core_state),
        .decoded_rd_address       (rd_addr),
        .decoded_rs_address       (rs_addr),
        .decoded_rt_address       (rt_addr),
        .decoded_reg_write_enable (reg_we),
        .decoded_reg_input_mux    (wb_mux),
        .decoded_immediate        (imm),
        .decoded_nzp_write_enable (nzp_we),
        .alu_out                  (alu_out),
        .lsu_out                  (lsu_out),
        .rs                       (rs),
        .rt                       (rt),
        .nzp                      (nzp)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] rd, input logic [1:0] mux,
                             input logic [7:0] a, input logic [7:0] l, input logic [7:0] i);
        core_state = ST_UPDATE;
        rd_addr    = rd;
        wb_mux     = mux;
        alu_out    = a;
        lsu_out    = l;
        imm        = i;
        reg_we     = 1'b1;
        tick();
        core_state = ST_IDLE;
        reg_we     = 1'b0;
    endtask

    task automatic read_regs(input logic [3:0] sa, input logic [3:0] ta);
        core_state = ST_REQUEST;
        rs_addr    = sa;
        rt_addr    = ta;
        tick();
        core_state = ST_IDLE;
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b1;
        block_id   = 8'd0;
        core_state = ST_IDLE;
        rd_addr    = 4'd0;
        rs_addr    = 4'd0;
        rt_addr    = 4'd0;
        reg_we     = 1'b0;
        wb_mux     = 2'b00;
        imm        = 8'h00;
        alu_out    = 8'h00;
        lsu_out    = 8'h00;
        nzp_we     = 1'b0;

        // Reset state and special registers
        #2;
        check_vec("reset_rs", rs, 8'h00);
        check_vec("reset_rt", rt, 8'h00);
        check_vec("reset_nzp", 8'(nzp), 8'h00);
        tick();
        reset = 1'b1;
        read_regs(4'd13, 4'd14);
        check_vec("r13_reset", rs, 8'h00);
        check_vec("r14_blockdim", rt, 8'h04);
        read_regs(4'd15, 4'd0);
        check_vec("r15_threadidx", rs, 8'h02);
        check_vec("r0_reset", rt, 8'h00);

        // Writeback from each source, rs==rt address allowed
        write_reg(4'd3, 2'b00, 8'h2A, 8'h00, 8'h00);
        read_regs(4'd3, 4'd3);
        check_vec("wb_alu_rs", rs, 8'h2A);
        check_vec("wb_alu_rt", rt, 8'h2A);
        write_reg(4'd3, 2'b01, 8'h00, 8'h11, 8'h00);
        read_regs(4'd3, 4'd0);
        check_vec("wb_lsu", rs, 8'h11);
        write_reg(4'd3, 2'b10, 8'h00, 8'h00, 8'h7F);
        read_regs(4'd0, 4'd3);
        check_vec("wb_imm", rt, 8'h7F);
        write_reg(4'd12, 2'b00, 8'hC3, 8'h00, 8'h00);
        read_regs(4'd12, 4'd3);
        check_vec("wb_r12", rs, 8'hC3);
        tick();
        tick();
        check_vec("rs_held", rs, 8'hC3);

        // Protection of special registers and reserved mux code
        write_reg(4'd14, 2'b00, 8'hFF, 8'h00, 8'h00);
        write_reg(4'd15, 2'b00, 8'hFF, 8'h00, 8'h00);
        read_regs(4'd14, 4'd15);
        check_vec("r14_protect", rs, 8'h04);
        check_vec("r15_protect", rt, 8'h02);
        write_reg(4'd5, 2'b00, 8'h55, 8'h00, 8'h00);
        write_reg(4'd5, 2'b11, 8'hAA, 8'hAA, 8'hAA);
        read_regs(4'd5, 4'd13);
        check_vec("mux_rsvd", rs, 8'h55);
        check_vec("r13_protect", rt, 8'h00);

        // State and enable gating
        write_reg(4'd1, 2'b00, 8'h10, 8'h00, 8'h00);
        core_state = ST_EXECUTE;
        rd_addr    = 4'd1;
        alu_out    = 8'h99;
        reg_we     = 1'b1;
        tick();
        enable     = 1'b0;
        core_state = ST_UPDATE;
        tick();
        reg_we     = 1'b0;
        core_state = ST_IDLE;
        enable     = 1'b1;
        read_regs(4'd1, 4'd5);
        check_vec("gate_r1", rs, 8'h10);
        enable   = 1'b0;
        block_id = 8'd7;
        tick();
        tick();
        core_state = ST_REQUEST;
        rs_addr    = 4'd3;
        tick();
        check_vec("gate_read_en0", rs, 8'h10);
        enable = 1'b1;
        read_regs(4'd13, 4'd13);
        check_vec("r13_frozen", rs, 8'h00);
        read_regs(4'd13, 4'd1);
        check_vec("r13_blockid", rs, 8'h07);

        // Compare flags
        core_state = ST_UPDATE;
        nzp_we     = 1'b1;
        alu_out    = 8'h02;
        tick();
        nzp_we     = 1'b0;
        core_state = ST_IDLE;
        check_vec("nzp_update", 8'(nzp), 8'(NZP_EXP));

        // Async reset between edges during UPDATE
        read_regs(4'd3, 4'd5);
        core_state = ST_UPDATE;
        rd_addr    = 4'd2;
        alu_out    = 8'h44;
        reg_we     = 1'b1;
        nzp_we     = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_vec("areset_rs", rs, 8'h00);
        check_vec("areset_rt", rt, 8'h00);
        check_vec("areset_nzp", 8'(nzp), 8'h00);
        tick();
        reg_we     = 1'b0;
        nzp_we     = 1'b0;
        core_state = ST_IDLE;
        reset      = 1'b1;
        read_regs(4'd2, 4'd3);
        check_vec("areset_r2", rs, 8'h00);
        check_vec("areset_r3", rt, 8'h00);
        read_regs(4'd14, 4'd15);
        check_vec("areset_r14", rs, 8'h04);
        check_vec("areset_r15", rt, 8'h02);
        write_reg(4'd4, 2'b00, 8'h21, 8'h00, 8'h00);
        read_regs(4'd4, 4'd13);
        check_vec("post_reset_wr", rs, 8'h21);
        check_vec("post_reset_r13", rt, 8'h07);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
